// File: rtl/csa_pkg.sv
// ============================================================================
// Module      : csa_pkg
// Description : Shared defaults and FSM encoding for the serial chunk adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    localparam int c_n_default = 3;
    localparam int c_k_default = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width: ceil(log2(k)), never narrower than one bit.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa.sv
// ============================================================================
// Module      : csa
// Description : N-bit carry-select adder; the upper half is precomputed for
//               both carry values and selected by the lower half's carry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa
    import csa_pkg::*;
#(
    parameter int N = c_n_default
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    localparam int c_lo = N / 2;
    localparam int c_hi = N - c_lo;

    generate
        if (N == 1) begin : g_single
            logic [1:0] w_full;
            assign w_full = {1'b0, a} + {1'b0, b} + {1'b0, ci};
            assign sum    = w_full[0];
            assign co     = w_full[1];
        end else begin : g_split
            logic [c_lo:0] w_lo;
            logic [c_hi:0] w_hi0;
            logic [c_hi:0] w_hi1;

            assign w_lo  = {1'b0, a[c_lo-1:0]} + {1'b0, b[c_lo-1:0]}
                         + {{c_lo{1'b0}}, ci};
            assign w_hi0 = {1'b0, a[N-1:c_lo]} + {1'b0, b[N-1:c_lo]};
            assign w_hi1 = {1'b0, a[N-1:c_lo]} + {1'b0, b[N-1:c_lo]}
                         + {{c_hi{1'b0}}, 1'b1};

            assign sum[c_lo-1:0]     = w_lo[c_lo-1:0];
            assign {co, sum[N-1:c_lo]} = w_lo[c_lo] ? w_hi1 : w_hi0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/serial_chunk_adder.sv
// ============================================================================
// Module      : serial_chunk_adder
// Description : W=N*K bit adder that processes one N-bit chunk per cycle
//               through a single carry-select adder, LSB chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_chunk_adder
    import csa_pkg::*;
#(
    parameter int N = c_n_default,
    parameter int K = c_k_default
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] sum,
    output logic           co
);

    localparam int c_w  = N * K;
    localparam int c_iw = idx_width(K);

    state_t          r_state;
    state_t          w_next_state;
    logic [c_w-1:0]  r_a;
    logic [c_w-1:0]  r_b;
    logic [c_w-1:0]  r_sum;
    logic            r_carry;
    logic [c_iw-1:0] r_idx;

    logic [N-1:0]    w_a_chunk;
    logic [N-1:0]    w_b_chunk;
    logic [N-1:0]    w_csa_sum;
    logic            w_csa_co;
    logic            w_last;

    assign w_last = (r_idx == c_iw'(K - 1));

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < K; i++) begin
            if (r_idx == c_iw'(i)) begin
                w_a_chunk = r_a[i*N +: N];
                w_b_chunk = r_b[i*N +: N];
            end
        end
    end

    csa #(.N(N)) u_csa (
        .a   (w_a_chunk),
        .b   (w_b_chunk),
        .ci  (r_carry),
        .sum (w_csa_sum),
        .co  (w_csa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operands are captured only on acceptance, so input changes during RUN
    // or DONE cannot disturb the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ci;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < K; i++) begin
                        if (r_idx == c_iw'(i)) begin
                            r_sum[i*N +: N] <= w_csa_sum;
                        end
                    end
                    r_carry <= w_csa_co;
                    if (!w_last) begin
                        r_idx <= r_idx + c_iw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign co        = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
// ============================================================================
// Module      : tb_serial_chunk_adder
// Description : Scoreboard bench for serial_chunk_adder (N=3, K=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_chunk_adder;

    localparam int N = 3;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;

    serial_chunk_adder #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] exp;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   npop      = 0;
    int   nsent     = 0;
    int   last_acc  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency on out_valid rise, hold stability in DONE, result on handshake.
    initial begin : monitor
        logic         prev_valid;
        logic         prev_ready;
        logic [W-1:0] prev_sum;
        logic         prev_co;
        exp_t         e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_sum   = '0;
        prev_co    = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) check("unexpected out_valid", 32'd1, 32'd0);
                    else                check("latency", 32'(cyc - sb[0].acc), 32'(K));
                end else if (!prev_ready) begin
                    check("hold sum", 32'(sum), 32'(prev_sum));
                    check("hold co", 32'(co), 32'(prev_co));
                end
                if (out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result {co,sum}", 32'({co, sum}), 32'(e.exp));
                    npop++;
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_sum   = sum;
            prev_co    = co;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                        input logic [W:0] exp, input bit hold_valid, input bit chk_spacing);
        bit got;
        a        = ta;
        b        = tb;
        ci       = tci;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back('{exp, cyc + 1});
            nsent++;
            if (chk_spacing && last_acc >= 0) check("accept spacing", 32'(cyc + 1 - last_acc), 32'(K + 2));
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        bit           seen;
        int           f0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset co", 32'(co), 32'd0);
        @(posedge clk);
        #1;

        // Wrap-around: all-ones plus one.
        out_ready = 1'b1;
        send(12'hFFF, 12'h001, 1'b0, 13'h1000, 1'b0, 1'b0);
        wait_idle();

        // in_ready low for the 5 cycles after accept; inputs changed mid-run.
        send(12'h123, 12'h456, 1'b1, 13'h057A, 1'b0, 1'b0);
        a = 12'hFFF;
        b = 12'hFFF;
        ci = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_ready busy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("in_ready after handshake", 32'(in_ready), 32'd1);
        wait_idle();

        // Back-pressure in DONE with a stray in_valid.
        out_ready = 1'b0;
        send(12'h7FF, 12'h001, 1'b0, 13'h0800, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("done reached", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 12'h555;
        b = 12'h0AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready in DONE", 32'(in_ready), 32'd0);
            check("out_valid held", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle after release in_ready", 32'(in_ready), 32'd1);
        check("idle after release out_valid", 32'(out_valid), 32'd0);
        check("stray in_valid ignored", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset on the second RUN edge discards the operation.
        send(12'hABC, 12'h111, 1'b0, 13'h0BCD, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        nsent--;
        @(negedge clk);
        check("mid-run reset sum", 32'(sum), 32'd0);
        check("mid-run reset co", 32'(co), 32'd0);
        check("mid-run reset out_valid", 32'(out_valid), 32'd0);
        check("mid-run reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(12'h001, 12'h001, 1'b0, 13'h0002, 1'b0, 1'b0);
        wait_idle();

        // Further boundary vectors.
        send(12'h000, 12'h000, 1'b1, 13'h0001, 1'b0, 1'b0);
        wait_idle();
        send(12'hFFF, 12'hFFF, 1'b1, 13'h1FFF, 1'b0, 1'b0);
        wait_idle();
        send(12'h924, 12'h492, 1'b0, 13'h0DB6, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back random traffic.
        f0 = fails;
        last_acc = -1;
        for (int i = 0; i < 1000; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            send(ra, rb, rci, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci}, 1'b1, i > 0);
        end
        in_valid = 1'b0;
        wait_idle();
        $display("[TB] back-to-back random in %m: %s (%0d errors)", (fails == f0) ? "pass" : "fail", fails - f0);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        check("results observed", 32'(npop), 32'(nsent));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
